// File: rtl/ib_pkg.sv
// Shared types for the UART->IB->meter byte path: byte type, handshake FSM states
// and the RTS hysteresis helper.
package ib_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    U_IDLE = 1'b0,
    U_HOLD = 1'b1
  } up_state_t;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_OFFER   = 2'd1,
    D_RELEASE = 2'd2
  } dn_state_t;

  // Raise at or above the high mark, drop at or below the low mark, otherwise hold.
  function automatic logic rts_hyst(input logic rts_cur, input logic at_hi, input logic at_lo);
    logic rts_new;
    if (at_hi) begin
      rts_new = 1'b1;
    end else if (at_lo) begin
      rts_new = 1'b0;
    end else begin
      rts_new = rts_cur;
    end
    return rts_new;
  endfunction

endpackage

// File: rtl/byte_fifo_core.sv
// Byte storage with write/read pointers and fill count; no handshake logic.
// The caller must not push when full or pop when empty.
module byte_fifo_core
  import ib_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         push,
  input  logic                         pop,
  input  byte_t                        wdata,
  output byte_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  byte_t         mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;

  // Storage write; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointer and fill-level bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and the IB I/O expander: 4-phase handshakes on both sides
// and a hysteretic RTS line so PC bursts survive slow meter polling.
module uart_rx_fifo
  import ib_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ack_n,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ack_n,
  output logic                         rts,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  up_state_t     up_r;
  up_state_t     up_nxt_s;
  dn_state_t     dn_r;
  dn_state_t     dn_nxt_s;
  logic          in_ack_n_r;
  logic          in_ack_n_nxt_s;
  logic          out_valid_r;
  logic          out_valid_nxt_s;
  byte_t         out_data_r;
  byte_t         out_data_nxt_s;
  logic          rts_r;
  logic          ack_meta_r;
  logic          ack_sync_r;
  logic          push_s;
  logic          pop_s;
  byte_t         rdata_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;

  byte_fifo_core #(.DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Two-flop synchroniser for the ioexp consume strobe; idles high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_meta_r <= 1'b1;
      ack_sync_r <= 1'b1;
    end else begin
      ack_meta_r <= out_ack_n;
      ack_sync_r <= ack_meta_r;
    end
  end

  // Handshake state and registered handshake outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      up_r        <= U_IDLE;
      in_ack_n_r  <= 1'b1;
      dn_r        <= D_IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      up_r        <= up_nxt_s;
      in_ack_n_r  <= in_ack_n_nxt_s;
      dn_r        <= dn_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
    end
  end

  // Upstream: take one byte per in_valid pulse, stall while full.
  always_comb begin
    up_nxt_s       = up_r;
    in_ack_n_nxt_s = in_ack_n_r;
    push_s         = 1'b0;
    case (up_r)
      U_IDLE: begin
        if (in_valid && !full_s) begin
          push_s         = 1'b1;
          in_ack_n_nxt_s = 1'b0;
          up_nxt_s       = U_HOLD;
        end else begin
          in_ack_n_nxt_s = 1'b1;
        end
      end
      U_HOLD: begin
        if (!in_valid) begin
          in_ack_n_nxt_s = 1'b1;
          up_nxt_s       = U_IDLE;
        end else begin
          in_ack_n_nxt_s = 1'b0;
        end
      end
      default: begin
        in_ack_n_nxt_s = 1'b1;
        up_nxt_s       = U_IDLE;
      end
    endcase
  end

  // Downstream: latch the head byte into out_data so it stays put while offered.
  always_comb begin
    dn_nxt_s        = dn_r;
    out_valid_nxt_s = out_valid_r;
    out_data_nxt_s  = out_data_r;
    pop_s           = 1'b0;
    case (dn_r)
      D_IDLE: begin
        if (!empty_s && ack_sync_r) begin
          out_data_nxt_s  = rdata_s;
          out_valid_nxt_s = 1'b1;
          dn_nxt_s        = D_OFFER;
        end else begin
          out_valid_nxt_s = 1'b0;
        end
      end
      D_OFFER: begin
        if (!ack_sync_r) begin
          out_valid_nxt_s = 1'b0;
          pop_s           = 1'b1;
          dn_nxt_s        = D_RELEASE;
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      D_RELEASE: begin
        if (ack_sync_r) begin
          dn_nxt_s = D_IDLE;
        end else begin
          dn_nxt_s = D_RELEASE;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        dn_nxt_s        = D_IDLE;
      end
    endcase
  end

  // RTS hysteresis on the current fill level; stop the host while in reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rts_r <= 1'b1;
    end else begin
      rts_r <= rts_hyst(rts_r, count_s >= CW'(RTS_HI), count_s <= CW'(RTS_LO));
    end
  end

  assign in_ack_n  = in_ack_n_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign rts       = rts_r;
  assign count     = count_s;

endmodule
